// File: rtl/alu_issue_queue.sv
// Out-of-order ALU issue queue: tag-based wakeup, oldest-ready select, one issue per cycle.
// Optional ALU_IQ_COUNT_EN adds a registered occupancy output iq_count.
package alu_iq_pkg;
  typedef enum logic [2:0] {
    ADD_I = 3'd0,
    SUB_I = 3'd1,
    AND_I = 3'd2,
    OR_I  = 3'd3,
    XOR_I = 3'd4,
    SLL_I = 3'd5,
    SRL_I = 3'd6,
    SLT_I = 3'd7
  } instr_opcode;
endpackage

module alu_issue_queue
  import alu_iq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  instr_opcode       disp_opcode,
  input  logic [31:0]       disp_src1_val,
  input  logic [31:0]       disp_src2_val,
  input  logic              disp_src1_rdy,
  input  logic              disp_src2_rdy,
  input  logic [TAG_W-1:0]  disp_src1_tag,
  input  logic [TAG_W-1:0]  disp_src2_tag,
  input  logic [TAG_W-1:0]  disp_dst_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [31:0]       cdb_value,
  output logic              alu_en,
  output instr_opcode       alu_opcode,
  output logic [31:0]       alu_val1,
  output logic [31:0]       alu_val2,
  output logic [TAG_W-1:0]  alu_dst_tag
`ifdef ALU_IQ_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] iq_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid, rdy1, rdy2;
  instr_opcode      op_q [DEPTH];
  logic [TAG_W-1:0] tag1 [DEPTH];
  logic [TAG_W-1:0] tag2 [DEPTH];
  logic [TAG_W-1:0] dst  [DEPTH];
  logic [31:0]      val1 [DEPTH];
  logic [31:0]      val2 [DEPTH];
  // age = number of valid entries older than this one; 0 is the oldest
  logic [AW-1:0]    age  [DEPTH];

  logic [DEPTH-1:0] eligible;
  logic             issue_any, free_any, disp_fire;
  logic [AW-1:0]    issue_idx, free_idx, best_age, new_age;
  logic [CW-1:0]    valid_cnt;

  always_comb begin
    eligible  = valid & rdy1 & rdy2;
    issue_any = 1'b0;
    issue_idx = '0;
    best_age  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (eligible[i] && (!issue_any || age[i] < best_age)) begin
        issue_any = 1'b1;
        issue_idx = AW'(i);
        best_age  = age[i];
      end
    end
  end

  always_comb begin
    free_any  = 1'b0;
    free_idx  = '0;
    valid_cnt = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_any = 1'b1;
        free_idx = AW'(i);
      end
      valid_cnt = valid_cnt + CW'(valid[i]);
    end
  end

  // Dispatch handshake: a transfer happens on a rising edge where disp_valid && disp_ready
  // and flush is low; disp_ready depends only on registered occupancy and rst, never on disp_valid.
  assign disp_ready = !rst && free_any;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign new_age    = AW'(valid_cnt - CW'(issue_any));

  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= '0;
      alu_en      <= 1'b0;
      alu_opcode  <= ADD_I;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_dst_tag <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (flush) begin
      valid  <= '0;
      alu_en <= 1'b0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      alu_en <= issue_any;
      if (issue_any) begin
        alu_opcode         <= op_q[issue_idx];
        alu_val1           <= val1[issue_idx];
        alu_val2           <= val2[issue_idx];
        alu_dst_tag        <= dst[issue_idx];
        valid[issue_idx]   <= 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i]) begin
          if (cdb_valid && !rdy1[i] && tag1[i] == cdb_tag) begin
            rdy1[i] <= 1'b1;
            val1[i] <= cdb_value;
          end
          if (cdb_valid && !rdy2[i] && tag2[i] == cdb_tag) begin
            rdy2[i] <= 1'b1;
            val2[i] <= cdb_value;
          end
          if (issue_any && age[i] > age[issue_idx]) age[i] <= age[i] - AW'(1);
        end
      end
      if (disp_fire) begin
        valid[free_idx] <= 1'b1;
        op_q[free_idx]  <= disp_opcode;
        tag1[free_idx]  <= disp_src1_tag;
        tag2[free_idx]  <= disp_src2_tag;
        dst[free_idx]   <= disp_dst_tag;
        age[free_idx]   <= new_age;
        // A result broadcast in the dispatch cycle would otherwise be missed forever
        if (!disp_src1_rdy && cdb_valid && disp_src1_tag == cdb_tag) begin
          rdy1[free_idx] <= 1'b1;
          val1[free_idx] <= cdb_value;
        end else begin
          rdy1[free_idx] <= disp_src1_rdy;
          val1[free_idx] <= disp_src1_val;
        end
        if (!disp_src2_rdy && cdb_valid && disp_src2_tag == cdb_tag) begin
          rdy2[free_idx] <= 1'b1;
          val2[free_idx] <= cdb_value;
        end else begin
          rdy2[free_idx] <= disp_src2_rdy;
          val2[free_idx] <= disp_src2_val;
        end
      end
    end
  end

`ifdef ALU_IQ_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || flush) iq_count <= '0;
    else              iq_count <= valid_cnt - CW'(issue_any) + CW'(disp_fire);
  end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized bench for alu_issue_queue: an age-ordered list model predicts every issue,
// a negedge monitor pops the expected queue whenever the ALU port fires.
module tb_alu_issue_queue;
  import alu_iq_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int EW    = 16 + 3 + 32 + 32 + TAG_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0, disp_valid = 1'b0, disp_ready;
  instr_opcode disp_opcode = ADD_I;
  logic [31:0] disp_src1_val = '0, disp_src2_val = '0;
  logic disp_src1_rdy = 1'b0, disp_src2_rdy = 1'b0;
  logic [TAG_W-1:0] disp_src1_tag = '0, disp_src2_tag = '0, disp_dst_tag = '0;
  logic cdb_valid = 1'b0;
  logic [TAG_W-1:0] cdb_tag = '0;
  logic [31:0] cdb_value = '0;
  logic alu_en;
  instr_opcode alu_opcode;
  logic [31:0] alu_val1, alu_val2;
  logic [TAG_W-1:0] alu_dst_tag;
`ifdef ALU_IQ_COUNT_EN
  logic [$clog2(DEPTH+1)-1:0] iq_count;
`endif

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
    .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_dst_tag(disp_dst_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_val1(alu_val1),
    .alu_val2(alu_val2), .alu_dst_tag(alu_dst_tag)
`ifdef ALU_IQ_COUNT_EN
    , .iq_count(iq_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit mon_on = 1'b0;

  typedef struct {
    logic [2:0]       op;
    bit               r1, r2;
    logic [31:0]      v1, v2;
    logic [TAG_W-1:0] t1, t2, dst;
  } ent_t;
  ent_t mq[$];                 // model entries, oldest first
  logic [EW-1:0] exp_q[$];     // {cycle, op, val1, val2, dst}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock cycle: drive inputs, advance the reference model, then cross the edge.
  task automatic step(input bit dv, input logic [2:0] op,
                      input bit r1, input logic [31:0] v1, input logic [TAG_W-1:0] t1,
                      input bit r2, input logic [31:0] v2, input logic [TAG_W-1:0] t2,
                      input logic [TAG_W-1:0] dtag,
                      input bit cv, input logic [TAG_W-1:0] ct, input logic [31:0] cval,
                      input bit fl, input bit rs);
    bit mready;
    int sel;
    ent_t e;
    rst = rs; flush = fl; disp_valid = dv; disp_opcode = instr_opcode'(op);
    disp_src1_rdy = r1; disp_src1_val = v1; disp_src1_tag = t1;
    disp_src2_rdy = r2; disp_src2_val = v2; disp_src2_tag = t2;
    disp_dst_tag = dtag; cdb_valid = cv; cdb_tag = ct; cdb_value = cval;
    #1;
    mready = !rs && (mq.size() < DEPTH);
    check("disp_ready", 32'(disp_ready), 32'(mready));
`ifdef ALU_IQ_COUNT_EN
    if (!rs) check("iq_count", 32'(iq_count), 32'(mq.size()));
`endif
    if (rs || fl) begin
      mq.delete();
    end else begin
      sel = -1;
      foreach (mq[i]) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
      if (sel >= 0) begin
        exp_q.push_back({16'(cyc + 1), mq[sel].op, mq[sel].v1, mq[sel].v2, mq[sel].dst});
        mq.delete(sel);
      end
      foreach (mq[i]) begin
        if (cv && !mq[i].r1 && mq[i].t1 == ct) begin mq[i].r1 = 1'b1; mq[i].v1 = cval; end
        if (cv && !mq[i].r2 && mq[i].t2 == ct) begin mq[i].r2 = 1'b1; mq[i].v2 = cval; end
      end
      if (dv && mready) begin
        e.op = op; e.dst = dtag;
        e.r1 = r1; e.v1 = v1; e.t1 = t1;
        e.r2 = r2; e.v2 = v2; e.t2 = t2;
        if (!r1 && cv && t1 == ct) begin e.r1 = 1'b1; e.v1 = cval; end
        if (!r2 && cv && t2 == ct) begin e.r2 = 1'b1; e.v2 = cval; end
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wake(input logic [TAG_W-1:0] t, input logic [31:0] v);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, t, v, 0, 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (mon_on) begin
      if (alu_en) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL alu_issue: unexpected issue dst=%0h at cycle %0d, expected none", alu_dst_tag, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e[EW-1 -: 16] !== 16'(cyc) || e[EW-17 -: 3] !== 3'(alu_opcode) ||
              e[TAG_W+63 -: 32] !== alu_val1 || e[TAG_W+31 -: 32] !== alu_val2 ||
              e[TAG_W-1:0] !== alu_dst_tag) begin
            fails++;
            $display("FAIL alu_issue: got cyc=%0d op=%0d v1=%0h v2=%0h dst=%0h expected cyc=%0d op=%0d v1=%0h v2=%0h dst=%0h",
                     cyc, alu_opcode, alu_val1, alu_val2, alu_dst_tag, e[EW-1 -: 16],
                     e[EW-17 -: 3], e[TAG_W+63 -: 32], e[TAG_W+31 -: 32], e[TAG_W-1:0]);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0][EW-1 -: 16] == 16'(cyc)) begin
        tests++;
        fails++;
        e = exp_q.pop_front();
        $display("FAIL alu_issue: got alu_en=0 at cycle %0d expected issue dst=%0h", cyc, e[TAG_W-1:0]);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    idle(0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("reset alu_en", 32'(alu_en), 0);
    check("reset alu_val1", alu_val1, 0);
    check("reset alu_val2", alu_val2, 0);
    check("reset alu_dst_tag", 32'(alu_dst_tag), 0);
    check("reset alu_opcode", 32'(alu_opcode), 0);
    mon_on = 1'b1;

    // ADD 5 + 7, both ready
    step(1, 0, 1, 5, 0, 1, 7, 0, 12, 0, 0, 0, 0, 0);
    idle(3);
    // SUB with src2 waiting on tag 3, woken two cycles later
    step(1, 1, 1, 2, 0, 0, 0, 3, 13, 0, 0, 0, 0, 0);
    idle(1);
    wake(3, 32'h10);
    idle(3);
    // src1 tag 9 captured from the CDB in the dispatch cycle
    step(1, 2, 0, 0, 9, 1, 1, 0, 14, 1, 9, 32'hAB, 0, 0);
    idle(3);
    // fill all entries blocked; entries 0 and 2 share tag 30
    step(1, 3, 0, 0, 30, 1, 1, 0, 20, 0, 0, 0, 0, 0);
    step(1, 4, 0, 0, 31, 1, 2, 0, 21, 0, 0, 0, 0, 0);
    step(1, 5, 1, 3, 0, 0, 0, 30, 22, 0, 0, 0, 0, 0);
    step(1, 6, 0, 0, 32, 1, 4, 0, 23, 0, 0, 0, 0, 0);
    step(1, 7, 1, 9, 0, 1, 9, 0, 24, 0, 0, 0, 0, 0);
    check("full disp_ready", 32'(disp_ready), 0);
    wake(30, 32'h55);
    idle(3);
    wake(31, 32'h66);
    wake(32, 32'h77);
    idle(3);
    // flush with three ready ops and a dispatch pending
    step(1, 0, 0, 0, 40, 1, 1, 0, 25, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 40, 1, 2, 0, 26, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 40, 1, 3, 0, 27, 1, 40, 32'h99, 0, 0);
    step(1, 3, 1, 1, 0, 1, 1, 0, 28, 0, 0, 0, 1, 0);
    check("flush alu_en", 32'(alu_en), 0);
    idle(3);
    // reset while the ALU port is active
    step(1, 0, 1, 32'hDEAD, 0, 1, 32'hBEEF, 0, 29, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h1234, 0, 1, 32'h5678, 0, 30, 0, 0, 0, 0, 0);
    check("pre-reset alu_en", 32'(alu_en), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("mid reset alu_en", 32'(alu_en), 0);
    check("mid reset alu_val1", alu_val1, 0);
    check("mid reset alu_val2", alu_val2, 0);
    check("mid reset alu_dst_tag", 32'(alu_dst_tag), 0);
    check("mid reset alu_opcode", 32'(alu_opcode), 0);
    idle(2);

    // random traffic with small tag space so wakeups are frequent
    for (int n = 0; n < 800; n++) begin
      bit r1, r2;
      r1 = ($urandom_range(0, 1) == 1);
      r2 = ($urandom_range(0, 1) == 1);
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           r1, $urandom, TAG_W'($urandom_range(0, 7)),
           r2, $urandom, TAG_W'($urandom_range(0, 7)),
           TAG_W'($urandom_range(0, 63)),
           $urandom_range(0, 1) == 1, TAG_W'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    end
    for (int t = 0; t < 8; t++) wake(TAG_W'(t), $urandom);
    idle(8);
    check("scoreboard drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
